// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the device
// over the open-collector clock and data lines. The sequence is: clock
// inhibit, request-to-send (data low), device-clocked shifting of 8 data
// bits LSB first, odd parity, stop, and the device ACK bit.
//
// Parameters:
//   INHIBIT_CYCLES - clk cycles the PS/2 clock is held low before RTS
//   TIMEOUT_CYCLES - max clk cycles allowed between device falling edges
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active low
//   tx_data[7:0] in   byte to send, captured on the accept cycle
//   tx_start     in   send request, honoured only while tx_busy is low
//   ps2_clk_in   in   raw PS/2 clock pad
//   ps2_data_in  in   raw PS/2 data pad
//   ps2_clk_oe   out  1 pulls the clock pad low
//   ps2_data_oe  out  1 pulls the data pad low
//   tx_busy      out  high from the accept cycle until back in IDLE
//   tx_done      out  one-cycle pulse on successful completion
//   tx_err       out  one-cycle pulse on timeout (or NACK, see below)
//
// Build option:
//   PS2_TX_ACK_CHECK_EN - when defined, a NACK (data high at the 11th
//   device falling edge) ends the frame with tx_err instead of tx_done.

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        clk_meta;
    logic        clk_sync;
    logic        clk_prev;
    logic        data_meta;
    logic        data_sync;
    logic        fe;

    logic [9:0]  frame;
    logic [3:0]  bit_cnt;
    logic [31:0] inhibit_cnt;
    logic [31:0] gap_cnt;
    logic        data_oe_q;
    logic        done_q;
    logic        err_q;
    logic        timeout;

    logic        frame_load;
    logic        inhibit_end;
    logic        shift_bit;
    logic        finish_ok;
    logic        finish_err;

`ifdef PS2_TX_ACK_CHECK_EN
    logic        ack_ok;
`endif

    assign fe      = clk_prev & ~clk_sync;
    assign timeout = (gap_cnt == TIMEOUT_CYCLES);

    // The clock line is pulled low only while inhibiting, so it can follow
    // the state register directly and is released the instant reset hits.
    assign ps2_clk_oe  = (state == INHIBIT);
    assign ps2_data_oe = data_oe_q;
    assign tx_busy     = (state != IDLE);
    assign tx_done     = done_q;
    assign tx_err      = err_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and one-cycle control strobes for the datapath.
    always_comb begin
        state_next  = state;
        frame_load  = 1'b0;
        inhibit_end = 1'b0;
        shift_bit   = 1'b0;
        finish_ok   = 1'b0;
        finish_err  = 1'b0;

        unique case (state)
            IDLE: begin
                if (tx_start) begin
                    frame_load = 1'b1;
                    state_next = INHIBIT;
                end
            end

            INHIBIT: begin
                if (inhibit_cnt == INHIBIT_CYCLES - 1) begin
                    inhibit_end = 1'b1;
                    state_next  = SHIFT;
                end
            end

            SHIFT: begin
                if (timeout) begin
                    finish_err = 1'b1;
                    state_next = IDLE;
                end else if (fe) begin
                    shift_bit = 1'b1;
                    // The edge with n = 9 drives the stop bit; the next
                    // falling edge belongs to the device ACK.
                    if (bit_cnt == 4'd9) begin
                        state_next = ACK;
                    end
                end
            end

            ACK: begin
                if (timeout) begin
                    finish_err = 1'b1;
                    state_next = IDLE;
                end else if (fe) begin
                    state_next = WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                if (timeout) begin
                    finish_err = 1'b1;
                    state_next = IDLE;
                end else if (clk_sync && data_sync) begin
                    state_next = IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
                    finish_ok  = ack_ok;
                    finish_err = ~ack_ok;
`else
                    finish_ok  = 1'b1;
`endif
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: pad synchronisers, frame shifter, counters and the
    // registered data drive and completion pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_meta    <= 1'b1;
            clk_sync    <= 1'b1;
            clk_prev    <= 1'b1;
            data_meta   <= 1'b1;
            data_sync   <= 1'b1;
            frame       <= '0;
            bit_cnt     <= '0;
            inhibit_cnt <= '0;
            gap_cnt     <= '0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_ok      <= 1'b0;
`endif
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;

            done_q <= finish_ok;
            err_q  <= finish_err;

            if (frame_load) begin
                frame       <= {1'b1, ~^tx_data, tx_data};
                bit_cnt     <= '0;
                inhibit_cnt <= '0;
            end else if (state == INHIBIT) begin
                inhibit_cnt <= inhibit_cnt + 32'd1;
            end

            // Gap counter only runs while waiting on the device; it stays
            // parked otherwise and is cleared again when SHIFT is entered.
            if (inhibit_end || fe) begin
                gap_cnt <= '0;
            end else if (state == SHIFT || state == ACK || state == WAIT_IDLE) begin
                gap_cnt <= gap_cnt + 32'd1;
            end

            // Start bit goes out as the clock is released; afterwards each
            // device falling edge presents the next frame bit. A 1 bit
            // (including stop) means the line is released.
            if (inhibit_end) begin
                data_oe_q <= 1'b1;
            end else if (shift_bit) begin
                data_oe_q <= ~frame[0];
                frame     <= {1'b0, frame[9:1]};
                bit_cnt   <= bit_cnt + 4'd1;
            end else if (finish_ok || finish_err) begin
                data_oe_q <= 1'b0;
            end

`ifdef PS2_TX_ACK_CHECK_EN
            if (state == ACK && fe) begin
                ack_ok <= ~data_sync;
            end
`endif
        end
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the send direction of the keyboard link that `ps2_kbd_top` receives on. It serialises one command byte (e.g. 0xED set-LEDs, 0xFF reset) onto the open-collector PS/2 clock and data lines. The sequence is: clock inhibit, request-to-send, device-clocked bit shifting, odd parity, stop, and device ACK. It sits in `top` beside the receiver and drives the pad tristate enables; `tx_busy` gates the receiver so it does not see the host's own frame.

## Interface
- `INHIBIT_CYCLES`, default 12000: clock-low hold before request-to-send (120 µs at 100 MHz).
- `TIMEOUT_CYCLES`, default 1500000: maximum gap allowed before the first device falling edge and between any two device falling edges (15 ms).
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `tx_data` in 8: byte to send; sampled on the accepting cycle.
- `tx_start` in 1: request; accepted only when `tx_busy`=0.
- `ps2_clk_in` in 1: raw PS/2 clock pad input.
- `ps2_data_in` in 1: raw PS/2 data pad input.
- `ps2_clk_oe` out 1: 1 pulls the clock pad low; 0 releases it.
- `ps2_data_oe` out 1: 1 pulls the data pad low; 0 releases it.
- `tx_busy` out 1: high from the accept cycle until return to IDLE.
- `tx_done` out 1: one-cycle pulse on successful completion.
- `tx_err` out 1: one-cycle pulse on timeout or missing ACK.

## Operation
- Pad inputs pass through a 2-flop synchroniser. A falling edge (`fe`) is registered when the synchronised clock was 1 in the previous cycle and is 0 in the current one.
- Frame shift register: {stop=1, parity=~^tx_data, tx_data[7:0]}, shifted LSB first. Bit counter is 4 bits, range 0..10.
- **IDLE:** both oe=0. On `tx_start`, latch the frame, clear the counters and go to INHIBIT.
- **INHIBIT:** `ps2_clk_oe`=1 for INHIBIT_CYCLES cycles. Then `ps2_data_oe`=1 (start bit 0), `ps2_clk_oe`=0, go to SHIFT.
- **SHIFT:** on each `fe` with bit counter n in 0..9, drive frame bit n: `ps2_data_oe` = ~bit. The stop bit therefore releases the data line. Increment n. After the `fe` that drives the stop bit (n becomes 10), go to ACK.
- **ACK:** on the next `fe`, sample the synchronised data. 0 means ACK; 1 means NACK. Go to WAIT_IDLE.
- **WAIT_IDLE:** wait until the synchronised clock and data are both 1. Then pulse `tx_done` on ACK or `tx_err` on NACK, and return to IDLE.
- **Timeout:** the gap counter clears on entry to SHIFT and on every `fe`. If it reaches TIMEOUT_CYCLES in SHIFT, ACK or WAIT_IDLE, release both lines, pulse `tx_err` and go to IDLE.
- `tx_start` while busy is ignored. `tx_data` changes after the accept cycle have no effect.
- The device holding the clock low during IDLE has no effect. The block never starts a frame on its own.

## Timing
- Reset (async, asserted low) forces immediately: `ps2_clk_oe`=0, `ps2_data_oe`=0, `tx_busy`=0, `tx_done`=0, `tx_err`=0, state IDLE. A frame in progress is abandoned, both lines are released, and no `tx_done` or `tx_err` is issued.
- `tx_busy` rises on the cycle after `tx_start` is sampled.
- `ps2_clk_oe` goes high on that same cycle and stays high for exactly INHIBIT_CYCLES cycles.
- `ps2_data_oe` asserts on the same cycle that `ps2_clk_oe` deasserts.
- Data update latency is 3 `clk` cycles after the pad falling edge (2 synchroniser flops plus 1 register). This is far inside the device's ~30 µs clock-low half period.
- `tx_done` and `tx_err` are mutually exclusive. Each pulse coincides with the cycle `tx_busy` falls.
- A new `tx_start` is accepted on the cycle after `tx_busy` falls.

## Configuration
- `PS2_TX_ACK_CHECK_EN` defined: a NACK (data=1 at the 11th `fe`) produces `tx_err`.
- Not defined: the ACK bit is not evaluated. Reaching WAIT_IDLE with both lines high always produces `tx_done`. Timeout still produces `tx_err`.

## Test plan
Bench uses INHIBIT_CYCLES=50, TIMEOUT_CYCLES=2000, and a device model that clocks at a 40-cycle period and samples data on the rising edge.
- **Send 0xED:** `tx_start`, tx_data=0xED → clock held low 50 cycles; device captures start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Device ACKs → single `tx_done` pulse and `tx_busy` falls.
- **Parity:** send 0x01, 0x00 and 0xFF → captured parity 0, 1 and 1 respectively. All frames complete with `tx_done`.
- **Busy request:** `tx_start` with 0x55 while busy sending 0xF4 → device receives only 0xF4. A following request issued after `tx_busy` falls sends 0x55.
- **Timeout:** device never clocks after the request-to-send → after 2000 cycles both oe=0, one `tx_err` pulse, `tx_busy`=0.
- **NACK:** device leaves data high on the ACK clock → `tx_err` with `PS2_TX_ACK_CHECK_EN` defined; `tx_done` without it.
- **Reset mid-frame:** assert `rst`=0 asynchronously after the 4th data bit → both oe=0 within the same cycle, no pulse on `tx_done` or `tx_err`. After release, a fresh 0xED send completes normally.
